// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and opcode helpers shared by core, wrapper and bench
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
  function automatic logic is_shift(input logic [2:0] op);
    return op == OP_SHL || op == OP_SHR;
  endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ADD/SUB/AND/OR/XOR with carry/borrow and signed overflow
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             v
);
  logic [WIDTH:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // result select; bit WIDTH of the difference is the unsigned borrow (a<b)
  always_comb begin
    r = op == OP_ADD ? sum[WIDTH-1:0] :
        op == OP_SUB ? dif[WIDTH-1:0] :
        op == OP_AND ? a & b :
        op == OP_OR  ? a | b : a ^ b;
    c = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? dif[WIDTH] : 1'b0;
    v = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]) :
        op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) & (dif[WIDTH-1] != a[WIDTH-1]) : 1'b0;
  end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle ALU with iterative shifts, shift-add MUL and valid/ready handshakes
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam logic [CNT_W-1:0] NW  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t st, st_n;
  logic [CNT_W-1:0]   cnt, n_len;
  logic [WIDTH-1:0]   ra, rb, sh, sh_n, cr, fin_r;
  logic [2:0]         rop;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH:0]     psum;
  logic               cc, cv, sc_n, fin_c, fin_v, big, last;
  alu_comb #(.WIDTH(WIDTH)) u_comb (.a(ra), .b(rb), .op(rop), .r(cr), .c(cc), .v(cv));
  assign in_ready  = st == ST_IDLE;
  assign out_valid = st == ST_DONE;
  assign last      = st == ST_EXEC && cnt == ONE;
  // iteration count: shifts run min(b,WIDTH) steps but never fewer than one edge
  always_comb begin
    big   = |b[WIDTH-1:CNT_W] | (b[CNT_W-1:0] >= NW);
    n_len = op_sel == OP_MUL ? NW :
            !is_shift(op_sel) ? ONE :
            b == '0 ? ONE : big ? NW : b[CNT_W-1:0];
  end
  // one shift step and one shift-add step; b=0 leaves the operand untouched
  always_comb begin
    sh_n  = rb == '0 ? sh : rop == OP_SHL ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    sc_n  = rb == '0 ? 1'b0 : rop == OP_SHL ? sh[WIDTH-1] : sh[0];
    psum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ra} : '0);
    acc_n = {psum, acc[WIDTH-1:1]};
  end
  // final result/flags as seen on the last EXEC edge
  always_comb begin
    fin_r = rop == OP_MUL ? acc_n[WIDTH-1:0] : is_shift(rop) ? sh_n : cr;
    fin_c = rop == OP_MUL ? |acc_n[2*WIDTH-1:WIDTH] : is_shift(rop) ? sc_n : cc;
    fin_v = rop == OP_MUL || is_shift(rop) ? 1'b0 : cv;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_n;
  end
  // next state: accept, count down, wait for consumer
  always_comb begin
    st_n = st;
    case (st)
      ST_IDLE: st_n = in_valid ? ST_EXEC : ST_IDLE;
      ST_EXEC: st_n = cnt == ONE ? ST_DONE : ST_EXEC;
      ST_DONE: st_n = out_ready ? ST_IDLE : ST_DONE;
      default: st_n = ST_IDLE;
    endcase
  end
  // operand capture, iteration datapath and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra        <= '0;
      rb        <= '0;
      rop       <= OP_ADD;
      cnt       <= '0;
      sh        <= '0;
      acc       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (st == ST_IDLE && in_valid) begin
      ra  <= a;
      rb  <= b;
      rop <= op_sel;
      cnt <= n_len;
      sh  <= a;
      acc <= {{WIDTH{1'b0}}, b};
    end else if (st == ST_EXEC) begin
      cnt <= cnt - ONE;
      sh  <= sh_n;
      acc <= acc_n;
      if (last) begin
        result    <= fin_r;
        carry_out <= fin_c;
        overflow  <= fin_v;
        zero      <= fin_r == '0;
        negative  <= fin_r[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed vectors with hand-computed results, latency and handshake checks
module tb_alu_seq_core;
  import alu_pkg::*;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [2:0] op_sel;
  logic       carry_out, overflow, zero, negative;
  int n_chk = 0, n_pass = 0;
  alu_seq_core #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op_sel(op_sel), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic op_run(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [2:0] top, input int n_exp, input logic [7:0] er,
                        input logic ec, input logic ev, input logic ez, input logic en);
    int lat;
    @(negedge clk);
    a = ta; b = tb; op_sel = top; in_valid = 1'b1;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, n_exp);
    check({tag, " result"}, result, er);
    check({tag, " carry"}, carry_out, ec);
    check({tag, " ovf"}, overflow, ev);
    check({tag, " zero"}, zero, ez);
    check({tag, " neg"}, negative, en);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op_sel = OP_ADD;
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst result", result, 0);
    check("rst flags", {carry_out, overflow, zero, negative}, 0);
    @(negedge clk); rst = 1'b0;
    op_run("add200_100", 8'd200, 8'd100, OP_ADD, 1, 8'd44,  1, 0, 0, 0);
    op_run("add100_100", 8'd100, 8'd100, OP_ADD, 1, 8'd200, 0, 1, 0, 1);
    op_run("sub5_10",    8'd5,   8'd10,  OP_SUB, 1, 8'd251, 1, 0, 0, 1);
    op_run("sub80_1",    8'h80,  8'h01,  OP_SUB, 1, 8'h7F,  0, 1, 0, 0);
    op_run("and",        8'hF0,  8'h3C,  OP_AND, 1, 8'h30,  0, 0, 0, 0);
    op_run("or",         8'h0F,  8'h80,  OP_OR,  1, 8'h8F,  0, 0, 0, 1);
    op_run("xor",        8'hAA,  8'hAA,  OP_XOR, 1, 8'h00,  0, 0, 1, 0);
    op_run("shl81_1",    8'h81,  8'd1,   OP_SHL, 1, 8'h02,  1, 0, 0, 0);
    op_run("shl5a_0",    8'h5A,  8'd0,   OP_SHL, 1, 8'h5A,  0, 0, 0, 0);
    op_run("shr80_9",    8'h80,  8'd9,   OP_SHR, 8, 8'h00,  1, 0, 1, 0);
    op_run("shr84_3",    8'h84,  8'd3,   OP_SHR, 3, 8'h10,  1, 0, 0, 0);
    op_run("mul20_13",   8'd20,  8'd13,  OP_MUL, 8, 8'h04,  1, 0, 0, 0);
    op_run("mul0_255",   8'd0,   8'd255, OP_MUL, 8, 8'h00,  0, 0, 1, 0);
    op_run("mul15_15",   8'd15,  8'd15,  OP_MUL, 8, 8'hE1,  0, 0, 0, 1);
    @(negedge clk);
    a = 8'd3; b = 8'd4; op_sel = OP_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin a = 8'hFF; b = 8'hFF; op_sel = OP_MUL; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp hold result", result, 7);
      check("bp hold flags", {carry_out, overflow, zero, negative}, 0);
      check("bp hold out_valid", out_valid, 1);
      check("bp in_ready low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);
    @(negedge clk);
    a = 8'd20; b = 8'd13; op_sel = OP_MUL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    check("midmul busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("midmul rst out_valid", out_valid, 0);
    check("midmul rst in_ready", in_ready, 1);
    check("midmul rst result", result, 0);
    check("midmul rst flags", {carry_out, overflow, zero, negative}, 0);
    @(negedge clk); rst = 1'b0;
    op_run("add1_1", 8'd1, 8'd1, OP_ADD, 1, 8'd2, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
